// File: rtl/fp16_add_arbiter.sv
// fp16_add_arbiter: round-robin arbiter that shares one multi-cycle FP16 adder
// core between NUM_REQ requesters. It grants one request at a time, issues the
// operation with a start/done handshake and returns the result tagged with the
// requester id on a shared response bus.
// Optional feature: define ARB_TIMEOUT_EN to enable a BUSY watchdog. When the
// watchdog expires, the arbiter returns qNaN with rsp_err=1.
module fp16_add_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_result,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  output logic                  add_start,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_op,
  input  logic                  add_done,
  input  logic [15:0]           add_result,
  output logic                  busy
);

  localparam logic [15:0] QNAN = 16'h7E00;

  // Reject parameter values the arbiter cannot support.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fp16_add_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("fp16_add_arbiter: TIMEOUT_CYC must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic [ID_W-1:0] grant_id;
  logic            grant_vld;
  logic [15:0]     a_nxt, b_nxt, res_nxt;
  logic            op_nxt;
  logic [ID_W-1:0] id_nxt;
  logic [15:0]     a_arr [NUM_REQ];
  logic [15:0]     b_arr [NUM_REQ];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wd_cnt, wd_nxt;
  logic       err_q, err_nxt;
`endif

  // Unpack the flat operand buses into per-requester words.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[16*gi +: 16];
    assign b_arr[gi] = req_b[16*gi +: 16];
  end

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    int unsigned scan;
    grant_vld = 1'b0;
    grant_id  = '0;
    scan      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = 32'(ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!grant_vld && req_valid[ID_W'(scan)]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(scan);
      end
    end
  end

  // Next-state and datapath-next logic; req_ready is the only combinational output.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    a_nxt     = add_a;
    b_nxt     = add_b;
    op_nxt    = add_op;
    id_nxt    = rsp_id;
    res_nxt   = rsp_result;
    req_ready = '0;
`ifdef ARB_TIMEOUT_EN
    wd_nxt    = wd_cnt;
    err_nxt   = err_q;
`endif
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant_id] = 1'b1;
          a_nxt     = a_arr[grant_id];
          b_nxt     = b_arr[grant_id];
          op_nxt    = req_sub[grant_id];
          id_nxt    = grant_id;
          ptr_nxt   = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
          state_nxt = ISSUE;
`ifdef ARB_TIMEOUT_EN
          err_nxt   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        state_nxt = BUSY;
`ifdef ARB_TIMEOUT_EN
        wd_nxt    = '0;
`endif
      end
      BUSY: begin
        if (add_done) begin
          res_nxt   = add_result;
          state_nxt = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_cnt == WD_LIMIT) begin
          res_nxt   = QNAN;
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end else begin
          wd_nxt = wd_cnt + 8'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  // State, pointer, operand/result registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_op     <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_valid  <= 1'b0;
      add_start  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      add_a      <= a_nxt;
      add_b      <= b_nxt;
      add_op     <= op_nxt;
      rsp_id     <= id_nxt;
      rsp_result <= res_nxt;
      rsp_valid  <= (state_nxt == RESP);
      add_start  <= (state_nxt == ISSUE);
      busy       <= (state_nxt != IDLE);
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter and error flag for the timeout substitute result.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= wd_nxt;
      err_q  <= err_nxt;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
